// File: rtl/serial_paralelo_lane.sv
// Serial-to-parallel lane receiver: bit-slides onto COM_SYMBOL, locks after LOCK_COUNT
// aligned COMs, then packs non-COM bytes MSB-first into 32-bit words. Optional: SP_DROP_CNT_EN.
module serial_paralelo_lane #(
  parameter logic [7:0]  COM_SYMBOL = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in,
  output logic [31:0] lane_out,
  output logic        valid_out,
`ifdef SP_DROP_CNT_EN
  output logic [7:0]  drop_count,
`endif
  output logic        active
);

  typedef enum logic [1:0] {HUNT, ALIGN, LOCKED} state_t;

  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

  state_t      state, state_nxt;
  logic [6:0]  shift_reg;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic [3:0]  com_cnt, com_cnt_nxt;
  logic [1:0]  byte_idx, byte_idx_nxt;
  logic [23:0] word_buf, word_buf_nxt;
  logic [31:0] lane_nxt;
  logic        valid_nxt, active_nxt, drop_evt;
  logic [7:0]  cand;
  logic        is_com, boundary;

  assign cand     = {shift_reg, data_in};
  assign is_com   = (cand == COM_SYMBOL);
  assign boundary = (bit_cnt == 3'd7);

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    com_cnt_nxt  = com_cnt;
    byte_idx_nxt = byte_idx;
    word_buf_nxt = word_buf;
    lane_nxt     = lane_out;
    valid_nxt    = 1'b0;
    active_nxt   = active;
    drop_evt     = 1'b0;
    case (state)
      HUNT: begin
        if (is_com) begin
          com_cnt_nxt = 4'd1;
          bit_cnt_nxt = 3'd0;
          state_nxt   = ALIGN;
        end
      end
      ALIGN: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_com) begin
            if (4'(com_cnt + 4'd1) >= LOCK_N) begin
              com_cnt_nxt  = LOCK_N;
              state_nxt    = LOCKED;
              active_nxt   = 1'b1;
              byte_idx_nxt = 2'd0;
            end else begin
              com_cnt_nxt = com_cnt + 4'd1;
            end
          end else begin
            com_cnt_nxt = 4'd0;
            state_nxt   = HUNT;
          end
        end
      end
      LOCKED: begin
        bit_cnt_nxt = bit_cnt + 3'd1;
        if (boundary) begin
          if (is_com) begin
            // A COM inside a word discards the partial word but keeps lock.
            drop_evt     = (byte_idx != 2'd0);
            byte_idx_nxt = 2'd0;
          end else begin
            byte_idx_nxt = byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf_nxt[23:16] = cand;
              2'd1: word_buf_nxt[15:8]  = cand;
              2'd2: word_buf_nxt[7:0]   = cand;
              default: begin
                lane_nxt  = {word_buf, cand};
                valid_nxt = 1'b1;
              end
            endcase
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= HUNT;
      shift_reg <= '0;
      bit_cnt   <= '0;
      com_cnt   <= '0;
      byte_idx  <= '0;
      word_buf  <= '0;
      lane_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nxt;
      shift_reg <= {shift_reg[5:0], data_in};
      bit_cnt   <= bit_cnt_nxt;
      com_cnt   <= com_cnt_nxt;
      byte_idx  <= byte_idx_nxt;
      word_buf  <= word_buf_nxt;
      lane_out  <= lane_nxt;
      valid_out <= valid_nxt;
      active    <= active_nxt;
    end
  end

`ifdef SP_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)
      drop_count <= '0;
    else if (drop_evt && drop_count != 8'hFF)
      drop_count <= drop_count + 8'd1;
  end
`else
  logic unused_drop;
  assign unused_drop = drop_evt;
`endif

endmodule

// File: tb/tb_serial_paralelo_lane.sv
// Bench for serial_paralelo_lane: byte/word-level reference model checked every cycle,
// plus directed scenario checks. Define SP_DROP_CNT_EN to also cover drop_count.
module tb_serial_paralelo_lane;

  localparam logic [7:0] COM  = 8'hBC;
  localparam int         LOCK = 4;

  logic        clk, reset, data_in;
  logic [31:0] lane_out;
  logic        valid_out, active;
`ifdef SP_DROP_CNT_EN
  logic [7:0]  drop_count;
`endif

  serial_paralelo_lane #(.COM_SYMBOL(COM), .LOCK_COUNT(LOCK)) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .lane_out(lane_out), .valid_out(valid_out),
`ifdef SP_DROP_CNT_EN
    .drop_count(drop_count),
`endif
    .active(active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0, checks = 0;

  // Reference model: 8-bit sliding window, mode 0=hunt 1=align 2=locked.
  int          m_win, m_mode, m_run, m_since, m_drops;
  logic [7:0]  m_word[$];
  logic [31:0] m_lane;
  bit          m_valid, m_active;
  int          mon_err, dut_pulses, mdl_pulses;

  task automatic model_reset();
    m_win = 0; m_mode = 0; m_run = 0; m_since = 0; m_drops = 0;
    m_word.delete(); m_lane = 0; m_valid = 0; m_active = 0;
  endtask

  task automatic model_step(input bit b);
    m_win   = ((m_win << 1) | int'(b)) & 255;
    m_valid = 0;
    if (m_mode == 0) begin
      if (m_win == int'(COM)) begin m_mode = 1; m_run = 1; m_since = 0; end
    end else begin
      m_since++;
      if (m_since % 8 == 0) begin
        if (m_mode == 1) begin
          if (m_win == int'(COM)) begin
            m_run++;
            if (m_run == LOCK) begin m_mode = 2; m_active = 1; m_word.delete(); end
          end else begin
            m_run = 0; m_mode = 0;
          end
        end else if (m_win == int'(COM)) begin
          if (m_word.size() > 0 && m_drops < 255) m_drops++;
          m_word.delete();
        end else begin
          m_word.push_back(8'(m_win));
          if (m_word.size() == 4) begin
            m_lane  = {m_word[0], m_word[1], m_word[2], m_word[3]};
            m_valid = 1;
            m_word.delete();
          end
        end
      end
    end
  endtask

  // Drives one bit, advances the model and tallies per-cycle disagreement.
  task automatic send_bit(input bit b);
    data_in = b;
    @(posedge clk);
    #1;
    model_step(b);
    if (valid_out !== m_valid || active !== m_active || lane_out !== m_lane) mon_err++;
    dut_pulses += int'(valid_out === 1'b1);
    mdl_pulses += int'(m_valid);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; data_in = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  task automatic lock_up();
    repeat (LOCK) send_byte(COM);
  endtask

  task automatic test_reset();
    do_reset(2);
    checks++; if ({lane_out, valid_out, active} !== 34'd0) begin errors++;
      $display("FAIL reset_init: lane=%h valid=%b active=%b want 0", lane_out, valid_out, active); end
    for (int i = 0; i < 20; i++) send_bit(1'($urandom));
    do_reset(1);
    checks++; if ({lane_out, valid_out, active} !== 34'd0) begin errors++;
      $display("FAIL reset_again: lane=%h valid=%b active=%b want 0", lane_out, valid_out, active); end
  endtask

  task automatic test_lock_first_word();
    logic [7:0] last;
    do_reset(2);
    repeat (LOCK - 1) send_byte(COM);
    last = COM;
    for (int i = 7; i >= 1; i--) send_bit(last[i]);
    checks++; if (active !== 1'b0) begin errors++;
      $display("FAIL lock_early: active=%b want 0", active); end
    send_bit(last[0]);
    checks++; if (active !== 1'b1) begin errors++;
      $display("FAIL lock_bit31: active=%b want 1", active); end
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    last = 8'h44;
    for (int i = 7; i >= 1; i--) send_bit(last[i]);
    checks++; if (valid_out !== 1'b0) begin errors++;
      $display("FAIL word_early: valid=%b want 0", valid_out); end
    send_bit(last[0]);
    checks++; if (valid_out !== 1'b1 || lane_out !== 32'h11223344) begin errors++;
      $display("FAIL first_word: valid=%b lane=%h want 1 11223344", valid_out, lane_out); end
    send_bit(1'b0);
    checks++; if (valid_out !== 1'b0 || lane_out !== 32'h11223344) begin errors++;
      $display("FAIL word_hold: valid=%b lane=%h want 0 11223344", valid_out, lane_out); end
  endtask

  task automatic test_insufficient_com();
    do_reset(1);
    repeat (LOCK - 1) send_byte(COM);
    send_byte(8'h55);
    checks++; if (active !== 1'b0) begin errors++;
      $display("FAIL short_com: active=%b want 0", active); end
    lock_up();
    checks++; if (active !== 1'b1) begin errors++;
      $display("FAIL relock: active=%b want 1", active); end
  endtask

  task automatic test_misalign();
    int p0;
    do_reset(1);
    send_bit(1); send_bit(0); send_bit(1);
    lock_up();
    p0 = dut_pulses;
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    checks++; if (lane_out !== 32'hAABBCCDD || dut_pulses - p0 !== 1) begin errors++;
      $display("FAIL misalign: lane=%h pulses=%0d want AABBCCDD 1", lane_out, dut_pulses - p0); end
  endtask

  task automatic test_back_to_back();
    int p0;
    do_reset(1);
    lock_up();
    p0 = dut_pulses;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    checks++; if (lane_out !== 32'h01020304) begin errors++;
      $display("FAIL b2b_word1: lane=%h want 01020304", lane_out); end
    send_byte(COM); send_byte(COM);
    checks++; if (dut_pulses - p0 !== 1) begin errors++;
      $display("FAIL idle_com: pulses=%0d want 1", dut_pulses - p0); end
    send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
    checks++; if (lane_out !== 32'h05060708 || dut_pulses - p0 !== 2) begin errors++;
      $display("FAIL b2b_word2: lane=%h pulses=%0d want 05060708 2", lane_out, dut_pulses - p0); end
  endtask

  task automatic test_mid_word_com();
    int p0;
    do_reset(1);
    lock_up();
    p0 = dut_pulses;
    send_byte(8'h99); send_byte(8'h88); send_byte(COM);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    checks++; if (lane_out !== 32'h01020304 || dut_pulses - p0 !== 1) begin errors++;
      $display("FAIL mid_com: lane=%h pulses=%0d want 01020304 1", lane_out, dut_pulses - p0); end
`ifdef SP_DROP_CNT_EN
    checks++; if (drop_count !== 8'd1) begin errors++;
      $display("FAIL drop_count: got %0d want 1", drop_count); end
`endif
  endtask

  task automatic test_reset_mid_word();
    int p0;
    logic [7:0] b2;
    do_reset(1);
    lock_up();
    send_byte(8'h11);
    b2 = 8'h22;
    for (int i = 7; i >= 4; i--) send_bit(b2[i]);
    do_reset(1);
    checks++; if ({lane_out, valid_out, active} !== 34'd0) begin errors++;
      $display("FAIL mid_reset: lane=%h valid=%b active=%b want 0", lane_out, valid_out, active); end
    p0 = dut_pulses;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    checks++; if (dut_pulses - p0 !== 0 || active !== 1'b0) begin errors++;
      $display("FAIL no_relock: pulses=%0d active=%b want 0 0", dut_pulses - p0, active); end
    lock_up();
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    checks++; if (lane_out !== 32'hDEADBEEF || dut_pulses - p0 !== 1) begin errors++;
      $display("FAIL after_relock: lane=%h pulses=%0d want DEADBEEF 1", lane_out, dut_pulses - p0); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      do_reset(1);
      for (int i = 0; i < int'($urandom_range(0, 15)); i++) send_bit(1'($urandom));
      lock_up();
      for (int t = 0; t < 60; t++) begin
        if ($urandom_range(0, 4) == 0) send_byte(COM);
        else send_byte(8'($urandom));
      end
    end
    checks++; if (mdl_pulses < 10) begin errors++;
      $display("FAIL rand_coverage: model pulses=%0d want >=10", mdl_pulses); end
`ifdef SP_DROP_CNT_EN
    checks++; if (int'(drop_count) !== m_drops) begin errors++;
      $display("FAIL rand_drops: got %0d want %0d", drop_count, m_drops); end
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; data_in = 1'b0;
    mon_err = 0; dut_pulses = 0; mdl_pulses = 0;
    model_reset();
    test_reset();
    test_lock_first_word();
    test_insufficient_com();
    test_misalign();
    test_back_to_back();
    test_mid_word_com();
    test_reset_mid_word();
    test_random();
    checks++; if (mon_err !== 0) begin errors++;
      $display("FAIL per_cycle_model: disagreeing cycles=%0d want 0", mon_err); end
    checks++; if (dut_pulses !== mdl_pulses) begin errors++;
      $display("FAIL pulse_total: got %0d want %0d", dut_pulses, mdl_pulses); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
